psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain_pkg.sv | 29 ++
 rtl/psum_bank.sv | 54 +++++
 rtl/psum_drain.sv | 170 +++++++++++++++++
 tb/tb_psum_drain.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: shared definitions for the partial-sum accumulate/drain block.
//   - state_t     : FSM state encoding (IDLE=0, ACCUM=1, DRAIN=2)
//   - DEF_WIDTH   : default result word width
//   - DEF_ROW/COL : default systolic array dimensions
//   - TC_W        : width of the tile counter
//   - sat_inc_tc  : saturating increment used by the tile counter
package psum_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ROW   = 4;
  localparam int DEF_COL   = 4;
  localparam int TC_W      = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TC_W-1:0] sat_inc_tc(input logic [TC_W-1:0] v);
    if (v == {TC_W{1'b1}}) begin
      sat_inc_tc = v;
    end else begin
      sat_inc_tc = v + {{(TC_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/psum_bank.sv
// psum_bank: N x WIDTH accumulator register array.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset (clears all words)
//   i_clear        : clear all words to zero
//   i_load         : parallel load of every word from i_data
//   i_data         : N packed words, word j at [(j+1)*WIDTH-1 : j*WIDTH]
//   i_rd_idx       : index for the single read port
//   o_rd_data      : word at i_rd_idx
//   o_acc          : all N words, same packing as i_data
// Clear has priority over load.
module psum_bank #(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int IW    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [IW-1:0]      i_rd_idx,
  output logic [WIDTH-1:0]   o_rd_data,
  output logic [N*WIDTH-1:0] o_acc
);

  logic [WIDTH-1:0] r_acc [N];

  // Accumulator storage: reset/clear to zero, otherwise parallel load or hold.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      for (int j = 0; j < N; j++) begin
        r_acc[j] <= {WIDTH{1'b0}};
      end
    end else if (i_load) begin
      for (int j = 0; j < N; j++) begin
        r_acc[j] <= i_data[j*WIDTH +: WIDTH];
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        r_acc[j] <= r_acc[j];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_pack
      assign o_acc[g*WIDTH +: WIDTH] = r_acc[g];
    end
  endgenerate

  assign o_rd_data = r_acc[i_rd_idx];

endmodule

// File: rtl/psum_drain.sv
// psum_drain: captures summed systolic tile results into an accumulator bank
// and drains the final values one word per cycle over a valid/ready port.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : begin (or restart) an accumulation job
//   i_tile_done      : i_tile_result valid this cycle
//   i_last_tile      : qualifies i_tile_done as the final tile of the job
//   i_tile_result    : N packed summed words
//   o_acc_out        : accumulator array fed back to the datapath
//   o_out_valid/i_out_ready/o_out_data/o_out_index/o_out_last : drain port
//   o_busy           : high in ACCUM and DRAIN
//   o_tile_count     : tiles captured in the current job (saturating)
//   o_overrun        : sticky flag, tile_done seen outside ACCUM
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROW   = DEF_ROW,
  parameter int COL   = DEF_COL,
  localparam int N    = ROW * COL,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_tile_done,
  input  logic               i_last_tile,
  input  logic [N*WIDTH-1:0] i_tile_result,
  output logic [N*WIDTH-1:0] o_acc_out,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_out_data,
  output logic [IW-1:0]      o_out_index,
  output logic               o_out_last,
  output logic               o_busy,
  output logic [TC_W-1:0]    o_tile_count,
  output logic               o_overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t            r_state;
  logic [IW-1:0]     r_index;
  logic [TC_W-1:0]   r_tile_count;
  logic              r_overrun;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_clear;
  logic              w_load;
  logic              w_xfer;

  // Bank control: start clears in IDLE/ACCUM (clear beats a same-cycle tile);
  // a tile is loaded only in ACCUM without start.
  always_comb begin
    w_clear = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = i_start;
      end
      ST_ACCUM: begin
        if (i_start) begin
          w_clear = 1'b1;
        end else begin
          w_load = i_tile_done;
        end
      end
      default: begin
        w_clear = 1'b0;
        w_load  = 1'b0;
      end
    endcase
  end

  assign w_xfer = r_out_valid & i_out_ready;

  // Control FSM with drain counter; outputs are registered alongside state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_index      <= {IW{1'b0}};
      r_tile_count <= {TC_W{1'b0}};
      r_overrun    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_ACCUM;
            r_tile_count <= {TC_W{1'b0}};
            r_overrun    <= 1'b0;
            r_busy       <= 1'b1;
          end else if (i_tile_done) begin
            r_overrun <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (i_start) begin
            r_tile_count <= {TC_W{1'b0}};
          end else if (i_tile_done) begin
            r_tile_count <= sat_inc_tc(r_tile_count);
            if (i_last_tile) begin
              r_state     <= ST_DRAIN;
              r_index     <= {IW{1'b0}};
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end else begin
            r_state <= ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          // start is deliberately ignored here; stray tiles flag overrun.
          if (i_tile_done) begin
            r_overrun <= 1'b1;
          end else begin
            r_overrun <= r_overrun;
          end
          if (w_xfer) begin
            if (r_index == LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_index     <= {IW{1'b0}};
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_index <= r_index + {{(IW-1){1'b0}}, 1'b1};
            end
          end else begin
            r_index <= r_index;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_index     <= {IW{1'b0}};
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  psum_bank #(
    .WIDTH (WIDTH),
    .N     (N),
    .IW    (IW)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_clear),
    .i_load    (w_load),
    .i_data    (i_tile_result),
    .i_rd_idx  (r_index),
    .o_rd_data (o_out_data),
    .o_acc     (o_acc_out)
  );

  // Index and bank contents are frozen during a stall, so data stays stable.
  assign o_out_valid  = r_out_valid;
  assign o_out_index  = r_index;
  assign o_out_last   = r_out_valid & (r_index == LAST_IDX);
  assign o_busy       = r_busy;
  assign o_tile_count = r_tile_count;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed self-checking bench for psum_drain (WIDTH=32, 4x4).
module tb_psum_drain;
  localparam int W = 32;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst, start, tile_done, last_tile, out_ready;
  logic [N*W-1:0] tile_result;
  logic [N*W-1:0] acc_out;
  logic           out_valid, out_last, busy, overrun;
  logic [W-1:0]   out_data;
  logic [3:0]     out_index;
  logic [7:0]     tile_count;

  int errors = 0;
  int checks = 0;

  psum_drain dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_tile_done   (tile_done),
    .i_last_tile   (last_tile),
    .i_tile_result (tile_result),
    .o_acc_out     (acc_out),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_out_index   (out_index),
    .o_out_last    (out_last),
    .o_busy        (busy),
    .o_tile_count  (tile_count),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word(input logic [N*W-1:0] v, input int j);
    return v[j*W +: W];
  endfunction

  task automatic set_all(input logic [W-1:0] v);
    for (int j = 0; j < N; j++) tile_result[j*W +: W] = v;
  endtask

  task automatic set_ramp(input logic [W-1:0] base);
    for (int j = 0; j < N; j++) tile_result[j*W +: W] = base + W'(j);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tile_done = 1'b0; last_tile = 1'b0;
    out_ready = 1'b0; tile_result = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (tile_count !== 8'd0) begin errors++; $display("FAIL reset_tc got=%0d exp=0", tile_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL reset_acc got=%h exp=0", acc_out[W-1:0]); end
    checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", out_index); end
  endtask

  task automatic test_single_tile();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%0b exp=1", busy); end
    set_ramp(32'd1); tile_done = 1'b1; last_tile = 1'b1;
    tick();
    tile_done = 1'b0; last_tile = 1'b0; out_ready = 1'b1;
    checks++; if (tile_count !== 8'd1) begin errors++; $display("FAIL single_tc got=%0d exp=1", tile_count); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(k + 1) || out_index !== 4'(k) || out_last !== (k == N - 1)) begin
        errors++;
        $display("FAIL single_word k=%0d got v=%0b d=%0d i=%0d l=%0b exp v=1 d=%0d i=%0d l=%0b",
                 k, out_valid, out_data, out_index, out_last, k + 1, k, (k == N - 1));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got v=%0b b=%0b exp 0 0", out_valid, busy); end
    checks++; if (word(acc_out, 5) !== 32'd6 || tile_count !== 8'd1) begin errors++; $display("FAIL single_hold got w5=%0d tc=%0d exp 6 1", word(acc_out, 5), tile_count); end
  endtask

  task automatic test_multi_tile();
    logic [W-1:0] vals [3];
    vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL multi_clear got w0=%0d exp 0", word(acc_out, 0)); end
    for (int t = 0; t < 3; t++) begin
      set_all(vals[t]); tile_done = 1'b1; last_tile = (t == 2);
      tick();
      tile_done = 1'b0; last_tile = 1'b0;
      checks++;
      if (word(acc_out, 0) !== vals[t] || word(acc_out, 15) !== vals[t] || tile_count !== 8'(t + 1)) begin
        errors++;
        $display("FAIL multi_acc t=%0d got w0=%0d w15=%0d tc=%0d exp %0d %0d %0d",
                 t, word(acc_out, 0), word(acc_out, 15), tile_count, vals[t], vals[t], t + 1);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd30 || out_index !== 4'(k)) begin
        errors++;
        $display("FAIL multi_drain k=%0d got v=%0b d=%0d i=%0d exp v=1 d=30 i=%0d", k, out_valid, out_data, out_index, k);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || tile_count !== 8'd3) begin errors++; $display("FAIL multi_end got v=%0b tc=%0d exp 0 3", out_valid, tile_count); end
  endtask

  task automatic test_stall();
    int exp_idx = 0;
    int cyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    set_ramp(32'd100); tile_done = 1'b1; last_tile = 1'b1;
    tick();
    tile_done = 1'b0; last_tile = 1'b0;
    while (out_valid === 1'b1 && cyc < 200) begin
      checks++;
      if (out_data !== W'(100 + exp_idx) || out_index !== 4'(exp_idx)) begin
        errors++;
        $display("FAIL stall_word cyc=%0d got d=%0d i=%0d exp d=%0d i=%0d", cyc, out_data, out_index, 100 + exp_idx, exp_idx);
      end
      out_ready = ((cyc % 3) == 0);
      tick();
      if (out_ready) exp_idx++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (exp_idx != N) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", exp_idx, N); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got busy=%0b exp 0", busy); end
  endtask

  task automatic test_overrun_idle();
    set_all(32'd55); tile_done = 1'b1; tick(); tile_done = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
    checks++; if (word(acc_out, 0) !== 32'd100 || word(acc_out, 15) !== 32'd115) begin errors++; $display("FAIL ovr_acc got w0=%0d w15=%0d exp 100 115", word(acc_out, 0), word(acc_out, 15)); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (overrun !== 1'b0 || busy !== 1'b1 || acc_out !== '0) begin errors++; $display("FAIL ovr_clear got ovr=%0b busy=%0b w0=%0d exp 0 1 0", overrun, busy, word(acc_out, 0)); end
  endtask

  task automatic test_rst_mid_drain();
    set_ramp(32'd1); tile_done = 1'b1; last_tile = 1'b1; tick();
    tile_done = 1'b0; last_tile = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || overrun !== 1'b0) begin errors++; $display("FAIL drain_start_ign got v=%0b i=%0d ovr=%0b exp 1 0 0", out_valid, out_index, overrun); end
    tile_done = 1'b1; tick(); tile_done = 1'b0;
    checks++; if (overrun !== 1'b1 || out_data !== 32'd1) begin errors++; $display("FAIL drain_ovr got ovr=%0b d=%0d exp 1 1", overrun, out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (out_index !== 4'd7 || out_data !== 32'd8) begin errors++; $display("FAIL rst_pre got i=%0d d=%0d exp 7 8", out_index, out_data); end
    rst = 1'b1; tick();
    checks++; if (out_valid !== 1'b0 || acc_out !== '0 || busy !== 1'b0 || overrun !== 1'b0 || out_index !== 4'd0) begin
      errors++; $display("FAIL rst_mid got v=%0b w0=%0d busy=%0b ovr=%0b i=%0d exp 0 0 0 0 0", out_valid, word(acc_out, 0), busy, overrun, out_index);
    end
    rst = 1'b0; tick(); tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after got v=%0b busy=%0b exp 0 0", out_valid, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_start_and_tile();
    start = 1'b1; tick();
    set_all(32'hFFFF_FFFF); tile_done = 1'b1;
    tick();
    start = 1'b0; tile_done = 1'b0;
    checks++; if (acc_out !== '0 || tile_count !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_wins got w0=%h tc=%0d busy=%0b exp 0 0 1", word(acc_out, 0), tile_count, busy);
    end
    set_all(32'hFFFF_FFFF); tile_done = 1'b1; tick(); tile_done = 1'b0;
    checks++; if (word(acc_out, 3) !== 32'hFFFF_FFFF || tile_count !== 8'd1) begin
      errors++; $display("FAIL after_clear got w3=%h tc=%0d exp ffffffff 1", word(acc_out, 3), tile_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_stall();
    test_overrun_idle();
    test_rst_mid_drain();
    test_start_and_tile();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
